// File: rtl/stream_demux4.sv
// stream_demux4: registered 1-to-4 stream demultiplexer with per-channel FIFOs.
// Each input word is pushed into the FIFO that in_sel selects. That FIFO's head
// word is presented on its own valid/ready output channel.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    input word
//   in_sel     destination channel 0..3
//   in_valid   input word/select valid
//   in_ready   input accepted this cycle (rst_n && !full[in_sel])
//   out_data   channel k head word in bits [k*WIDTH +: WIDTH]
//   out_valid  bit k: channel k non-empty
//   out_ready  bit k: sink k takes its head word
//   busy       at least one channel FIFO non-empty
module stream_demux4 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic                 busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [3:0] full;
    logic [3:0] empty;

    // A full channel never accepts, even if it pops in the same cycle.
    assign in_ready = rst_n && !full[in_sel];

    // Derived only from the count registers, so it cannot glitch on input changes.
    assign busy = |(~empty);

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;
        logic             push;
        logic             pop;

        assign push     = in_valid && in_ready && (in_sel == 2'(k));
        assign pop      = out_ready[k] && !empty[k];
        assign full[k]  = (count == CNT_W'(DEPTH));
        assign empty[k] = (count == '0);

        // Pointers wrap naturally because DEPTH is a power of two.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (!push && pop) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

        assign out_data[k*WIDTH +: WIDTH] = mem[rd_ptr];
        assign out_valid[k]               = !empty[k];
    end

endmodule

// File: tb/tb_stream_demux4.sv
// Testbench for stream_demux4: directed scenarios plus random traffic, with a
// per-channel queue model as scoreboard and an independent monitor process.
module tb_stream_demux4;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready = '0;
    logic               busy;

    always #5 clk = ~clk;

    stream_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Reference model: words accepted but not yet delivered, per channel.
    logic [WIDTH-1:0] q [4][$];
    int               checks = 0;
    int               failures = 0;
    logic             pend = 1'b0;   // a push was recorded this cycle (not yet in DUT)
    logic [1:0]       psel = '0;
    logic             mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; records an accepted word into the model.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] s,
                       input logic [3:0] r, output logic acc);
        @(negedge clk);
        pend      = 1'b0;
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
        #1;
        acc = v && in_ready;
        if (acc) begin
            q[s].push_back(d);
            pend = 1'b1;
            psel = s;
        end
    endtask

    // Retry until accepted, bounded.
    task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] s, input logic [3:0] r);
        logic acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            cyc(1'b1, d, s, r, acc);
        end
        if (!acc) chk("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n, input logic [3:0] r);
        logic acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 2'(i), r, acc);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        pend     = 1'b0;
        in_valid = 1'b0;
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
        chk("rst_mid_busy", 32'(busy), 32'(0));
        chk("rst_mid_in_ready", 32'(in_ready), 32'(0));
        for (int k = 0; k < 4; k++) q[k].delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    // Monitor: compares DUT outputs with the model every cycle, pops on handshake.
    initial begin : monitor
        int   cnt [4];
        logic exp_busy;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                exp_busy = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    cnt[k] = q[k].size() - ((pend && psel == 2'(k)) ? 1 : 0);
                    if (cnt[k] > 0) exp_busy = 1'b1;
                end
                chk("in_ready", 32'(in_ready), 32'(cnt[in_sel] < int'(DEPTH)));
                chk("busy", 32'(busy), 32'(exp_busy));
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(cnt[k] > 0));
                    if (cnt[k] > 0) begin
                        chk($sformatf("out_data%0d", k), 32'(out_data[k*WIDTH +: WIDTH]),
                            32'(q[k][0]));
                        if (out_ready[k]) void'(q[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic acc;
        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("idle_in_ready_sel%0d", s), 32'(in_ready), 32'(1));
        end
        chk("idle_out_data", 32'(out_data), 32'(0));
        mon_en = 1'b1;
        idle(3, 4'b0000);

        // Single routing
        send(4'hA, 2'd2, 4'b1111);
        idle(3, 4'b1111);

        // Fill and drain channel 1; no pass-through when full
        send(4'h1, 2'd1, 4'b0000);
        send(4'h2, 2'd1, 4'b0000);
        cyc(1'b1, 4'h3, 2'd1, 4'b0000, acc);
        chk("full_hold_off", 32'(acc), 32'(0));
        cyc(1'b1, 4'h3, 2'd1, 4'b0010, acc);
        chk("full_no_passthru", 32'(acc), 32'(0));
        send(4'h3, 2'd1, 4'b0010);
        idle(3, 4'b0010);

        // Independent sinks: channel 0 stalled full, channel 3 streams at full rate
        send(4'h9, 2'd0, 4'b0000);
        send(4'h4, 2'd0, 4'b0000);
        for (int d = 5; d <= 8; d++) begin
            cyc(1'b1, 4'(d), 2'd3, 4'b1000, acc);
            chk("ch3_throughput", 32'(acc), 32'(1));
        end
        idle(2, 4'b1000);
        chk("ch0_still_full", 32'(out_valid[0]), 32'(1));
        idle(3, 4'b1111);

        // Simultaneous push and pop on channel 2
        send(4'hB, 2'd2, 4'b0000);
        cyc(1'b1, 4'hC, 2'd2, 4'b0100, acc);
        chk("pushpop_accept", 32'(acc), 32'(1));
        idle(2, 4'b0000);
        idle(2, 4'b1111);

        // Reset mid-stream with channels 0 and 3 holding two words each
        send(4'h1, 2'd0, 4'b0000);
        send(4'h2, 2'd0, 4'b0000);
        send(4'hE, 2'd3, 4'b0000);
        send(4'hF, 2'd3, 4'b0000);
        reset_mid();
        idle(4, 4'b1111);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 4'($urandom), acc);
        end
        idle(10, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drained%0d", k), 32'(q[k].size()), 32'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
